uart_rx_axis_fifo: RTL and testbench

//  Parametrised UART receiver with an AXI-Stream master output.

---
 rtl/uart_rx_axis_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_axis_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver (5..9 data bits, optional parity, 1/2 stop bits) feeding a
// first-word-fall-through FIFO with an AXI-Stream master output and per-word error flags.
module uart_rx_axis_fifo #(
    parameter int CLK_FREQ    = 100,
    parameter int BIT_RATE    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic [2:0]                    m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);

    localparam int CPP  = CLK_FREQ * 1000000 / BIT_RATE;
    localparam int HALF = CPP / 2;
    localparam int CW   = (CPP > 1) ? $clog2(CPP) : 1;
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WW   = DATA_BITS + 3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP1     = 3'd4;
    localparam logic [2:0] S_STOP2     = 3'd5;
    localparam logic [2:0] S_WRITE     = 3'd6;
    localparam logic [2:0] S_WAIT_HIGH = 3'd7;

    // ---------------- rx synchroniser and edge detect ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   rs_d;
    logic                   fall;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= '1;
            rs_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rs_d   <= rs;
        end
    end

    assign rs   = sync_q[SYNC_STAGES-1];
    assign fall = rs_d & ~rs;

    // ---------------- receive FSM ----------------
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_s;
    logic                 perr;
    logic                 ferr;
    logic                 brk;
    logic                 last_stop;
    logic                 wr_pend;
    logic [WW-1:0]        wr_word;
    logic                 tick;
    logic                 half_tick;

    assign tick      = (cnt == CW'(CPP - 1));
    assign half_tick = (cnt == CW'(HALF - 1));
    assign dbg_state = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_s     <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            brk       <= 1'b0;
            last_stop <= 1'b1;
            wr_pend   <= 1'b0;
            wr_word   <= '0;
        end else begin
            wr_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    par_s   <= 1'b0;
                    perr    <= 1'b0;
                    if (fall) state <= S_START;
                end
                S_START: begin
                    if (half_tick) begin
                        cnt   <= '0;
                        state <= rs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shreg   <= {rs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BW'(DATA_BITS - 1))
                            state <= (PARITY_BIT != 0) ? S_PARITY : S_STOP1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt   <= '0;
                        par_s <= rs;
                        // odd parity wants an odd total of ones, even parity an even total
                        perr  <= ((^shreg) ^ rs) != (PARITY_BIT == 1);
                        state <= S_STOP1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP1: begin
                    if (tick) begin
                        cnt       <= '0;
                        ferr      <= ~rs;
                        brk       <= (shreg == '0) & ~par_s & ~rs;
                        last_stop <= rs;
                        state     <= (STOP_BITS == 2) ? S_STOP2 : S_WRITE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP2: begin
                    if (tick) begin
                        cnt       <= '0;
                        ferr      <= ferr | ~rs;
                        last_stop <= rs;
                        state     <= S_WRITE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    wr_pend <= 1'b1;
                    wr_word <= {brk, ferr, perr, shreg};
                    state   <= last_stop ? S_IDLE : S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    // a line held low must go high before a new start is accepted
                    if (rs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- FWFT FIFO ----------------
    // Handshake: a beat transfers on a rising aclk edge where tvalid and tready are
    // both high; while tvalid is high and tready low, tdata/tuser hold their value.
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic [WW-1:0] head;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = m_axis_tvalid & m_axis_tready;
    assign push  = wr_pend & (~full | pop);
    assign head  = mem[rp];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wp] <= wr_word;
    end

    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head[WW-1:DATA_BITS] : 3'b000;
    assign overrun       = wr_pend & full & ~pop;
    assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench for uart_rx_axis_fifo: directed frames, error/break/glitch cases, FIFO overflow,
// mid-frame reset, then a randomized streaming phase checked against a word-level model.
module tb_uart_rx_axis_fifo;

    localparam int CPP = 16;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        rx;
    logic [7:0]  m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overrun;
    logic [2:0]  fifo_count;
    logic [2:0]  dbg_state;

    int checks  = 0;
    int errors  = 0;
    int ov_seen = 0;
    logic [10:0] exp_q[$];

    always #5 aclk = ~aclk;

    uart_rx_axis_fifo #(
        .CLK_FREQ(16), .BIT_RATE(1000000), .DATA_BITS(8), .PARITY_BIT(2),
        .STOP_BITS(1), .FIFO_DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .rx(rx),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .overrun(overrun), .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n cycles, sampling 1 ns after each rising edge
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
            if (overrun) ov_seen++;
        end
    endtask

    // even parity: the correct bit makes the total count of ones even
    function automatic logic parity_bit(input logic [7:0] d, input bit ok);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return ok ? logic'(ones % 2) : logic'(1 - ones % 2);
    endfunction

    function automatic logic [10:0] model_word(input logic [7:0] d, input bit ok, input bit stop);
        logic perr, ferr, brk;
        perr = !ok;
        ferr = !stop;
        brk  = (d == 8'h00) && (parity_bit(d, ok) == 1'b0) && !stop;
        return {brk, ferr, perr, d};
    endfunction

    // drive start, data, parity and stop; returns right after the stop bit is driven
    task automatic send_to_stop(input logic [7:0] d, input bit ok, input bit stop);
        logic [10:0] bits;
        bits = {logic'(stop), parity_bit(d, ok), d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            rx = bits[k];
            if (k < 10) wait_cycles(CPP);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ok, input bit stop);
        send_to_stop(d, ok, stop);
        wait_cycles(CPP);
        rx = 1'b1;
        wait_cycles(2 * CPP);
    endtask

    task automatic drain(input int n);
        int t;
        m_axis_tready = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!m_axis_tvalid && t < 400) begin
                wait_cycles(1);
                t++;
            end
            check("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("drain_beat", 32'({m_axis_tuser, m_axis_tdata}), 32'(exp_q.pop_front()));
            wait_cycles(1);
        end
        m_axis_tready = 1'b0;
    endtask

    initial begin
        logic [7:0]  d;
        bit          ok, st;
        int          got, t;
        bit          holding;
        logic [10:0] held;

        rx = 1'b1;
        m_axis_tready = 1'b0;
        aresetn = 1'b0;
        wait_cycles(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        aresetn = 1'b1;
        wait_cycles(5);

        // clean 0xA5 with tready high; tvalid rises 2 cycles after the stop sample
        m_axis_tready = 1'b1;
        send_to_stop(8'hA5, 1'b1, 1'b1);
        wait_cycles(12);
        check("t1_tvalid_early", 32'(m_axis_tvalid), 32'd0);
        wait_cycles(1);
        check("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t1_beat", 32'({m_axis_tuser, m_axis_tdata}), 32'(model_word(8'hA5, 1'b1, 1'b1)));
        wait_cycles(CPP);
        rx = 1'b1;
        wait_cycles(2 * CPP);
        check("t1_count", 32'(fifo_count), 32'd0);
        m_axis_tready = 1'b0;

        // parity error, then framing error
        exp_q.push_back(model_word(8'h07, 1'b0, 1'b1));
        send_frame(8'h07, 1'b0, 1'b1);
        exp_q.push_back(model_word(8'h3C, 1'b1, 1'b0));
        send_frame(8'h3C, 1'b1, 1'b0);
        check("t23_count", 32'(fifo_count), 32'd2);
        drain(2);

        // break: line held low for 20 bit periods yields exactly one word
        rx = 1'b0;
        wait_cycles(20 * CPP);
        check("brk_count_low", 32'(fifo_count), 32'd1);
        wait_cycles(100);
        check("brk_count_still", 32'(fifo_count), 32'd1);
        rx = 1'b1;
        wait_cycles(4 * CPP);
        check("brk_count_high", 32'(fifo_count), 32'd1);
        exp_q.push_back(model_word(8'h00, 1'b1, 1'b0));
        drain(1);

        // low pulse shorter than half a bit: the mid-start sample sees the line high again
        rx = 1'b0;
        wait_cycles(4);
        check("glitch_start", 32'(dbg_state), 32'(ST_START));
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_tvalid", 32'(m_axis_tvalid), 32'd0);

        // overflow: fifth word dropped with a single overrun pulse
        ov_seen = 0;
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(model_word(8'(v), 1'b1, 1'b1));
            send_frame(8'(v), 1'b1, 1'b1);
        end
        check("ovf_count4", 32'(fifo_count), 32'd4);
        check("ovf_none_yet", 32'(ov_seen), 32'd0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("ovf_pulse", 32'(ov_seen), 32'd1);
        check("ovf_count_full", 32'(fifo_count), 32'd4);
        drain(4);
        check("ovf_drained", 32'(fifo_count), 32'd0);

        // reset in the middle of a frame with two words queued
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        check("mid_count2", 32'(fifo_count), 32'd2);
        rx = 1'b0;
        wait_cycles(40);
        #3;
        aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_tuser", 32'(m_axis_tuser), 32'd0);
        rx = 1'b1;
        wait_cycles(2);
        aresetn = 1'b1;
        wait_cycles(10);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.push_back(model_word(8'h5A, 1'b1, 1'b1));
        send_frame(8'h5A, 1'b1, 1'b1);
        drain(1);

        // randomized streaming with random backpressure
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d  = (i == 5) ? 8'h00 : 8'($urandom_range(0, 255));
                    ok = ($urandom_range(0, 3) != 0);
                    st = ($urandom_range(0, 3) != 0);
                    exp_q.push_back(model_word(d, ok, st));
                    send_frame(d, ok, st);
                end
            end
            begin
                got = 0;
                t = 0;
                holding = 1'b0;
                held = '0;
                while (got < 12 && t < 6000) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    if (m_axis_tvalid && holding)
                        check("rnd_stable", 32'({m_axis_tuser, m_axis_tdata}), 32'(held));
                    if (m_axis_tvalid && m_axis_tready) begin
                        check("rnd_beat", 32'({m_axis_tuser, m_axis_tdata}), 32'(exp_q.pop_front()));
                        got++;
                        holding = 1'b0;
                    end else if (m_axis_tvalid) begin
                        holding = 1'b1;
                        held = {m_axis_tuser, m_axis_tdata};
                    end
                    wait_cycles(1);
                    t++;
                end
                m_axis_tready = 1'b0;
                check("rnd_beats", 32'(got), 32'd12);
            end
        join
        wait_cycles(50);
        check("end_count", 32'(fifo_count), 32'd0);
        check("end_overrun", 32'(ov_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
